// File: rtl/rcas_acc_16bit_pkg.sv
//------------------------------------------------------------------------------
// rcas_acc_16bit_pkg
//
// Purpose : Shared definitions for the 16-bit ripple-carry add/subtract
//           accumulator. Holds the datapath width, the default operand-count
//           width, the controller state encoding and the signed-overflow
//           helper used by the accumulator.
//
// Contents: WIDTH       - datapath width, fixed at 16 by the adder
//           LEN_W_DEF   - default width of the operand-count input
//           state_t     - IDLE / RUN / DONE controller states
//           op_overflow - two's-complement overflow test for one operation
//------------------------------------------------------------------------------
package rcas_acc_16bit_pkg;

    localparam int WIDTH     = 16;
    localparam int LEN_W_DEF = 4;

    // Encoding 2'd3 is unused; the controller steers it back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow from the sign bits alone: an add overflows when both
    // operands share a sign that the result does not; a subtract overflows
    // when the operand signs differ and the result's sign leaves the
    // minuend's sign.
    function automatic logic op_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic sub
    );
        logic w_sign_cond;
        w_sign_cond = sub ? (a_msb != b_msb) : (a_msb == b_msb);
        return w_sign_cond && (r_msb != a_msb);
    endfunction

endpackage : rcas_acc_16bit_pkg

// File: rtl/rcas_acc_16bit_if.sv
//------------------------------------------------------------------------------
// rcas_acc_16bit_if
//
// Purpose : Bundles the command, operand-stream and result-stream signals of
//           the accumulator into one interface.
//
// Signals : start     - begin a new accumulation (honoured only when idle)
//           len       - number of operands in the sequence, taken with start
//           in_valid  - operand present on in_data / in_sub
//           in_ready  - accumulator can take an operand this cycle
//           in_data   - operand
//           in_sub    - 0: acc + in_data, 1: acc - in_data
//           out_valid - final result presented on acc / c_out / ovf / zero
//           out_ready - consumer takes the result
//           acc       - accumulator value
//           c_out     - carry of the latest operation (subtract: 1 = no borrow)
//           ovf       - sticky signed overflow over the sequence
//           zero      - acc == 0
//
// Modports: master - the side that issues commands and operands
//           slave  - the accumulator
//------------------------------------------------------------------------------
interface rcas_acc_16bit_if #(
    parameter int LEN_W = rcas_acc_16bit_pkg::LEN_W_DEF
);
    import rcas_acc_16bit_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output start, len, in_valid, in_data, in_sub, out_ready,
        input  in_ready, out_valid, acc, c_out, ovf, zero
    );

    modport slave (
        input  start, len, in_valid, in_data, in_sub, out_ready,
        output in_ready, out_valid, acc, c_out, ovf, zero
    );

endinterface : rcas_acc_16bit_if

// File: rtl/rcas_16bit.sv
//------------------------------------------------------------------------------
// rcas_16bit
//
// Purpose : 16-bit ripple-carry adder/subtractor. With i_sel = 0 it returns
//           i_a + i_b; with i_sel = 1 it returns i_a - i_b, formed as
//           i_a + ~i_b + 1. The result wraps modulo 2^16.
//
// Ports   : i_a    in  16  first operand (accumulator side)
//           i_b    in  16  second operand
//           i_sel  in   1  0: add, 1: subtract
//           o_sum  out 16  result
//           o_cout out  1  carry out of bit 15 (subtract: 1 = no borrow)
//------------------------------------------------------------------------------
module rcas_16bit
    import rcas_acc_16bit_pkg::*;
(
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_b_eff;

    // Conditional inversion of b; the +1 of the two's complement enters as
    // the carry into bit 0.
    assign w_b_eff = i_b ^ {WIDTH{i_sel}};

    // NOTE: blocking assignments are deliberate here: the carry variable has
    // to ripple from bit to bit within one evaluation of the block, which is
    // exactly what combinational logic means. State elements use <= instead.
    always_comb begin
        logic w_c;
        w_c   = i_sel;
        o_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ w_b_eff[i] ^ w_c;
            w_c      = (i_a[i] & w_b_eff[i]) | (w_c & (i_a[i] ^ w_b_eff[i]));
        end
        o_cout = w_c;
    end

endmodule : rcas_16bit

// File: rtl/rcas_acc_16bit.sv
//------------------------------------------------------------------------------
// rcas_acc_16bit
//
// Purpose : Sequenced add/subtract accumulator. A start command clears the
//           accumulator and loads an operand count; the block then accepts
//           that many operands over a valid/ready stream, adding or
//           subtracting each one through a single rcas_16bit instance, and
//           finally presents the result until the consumer takes it.
//           Overflow is sticky across the sequence; the result wraps.
//
// Ports   : clk  in  1  clock, state changes on the rising edge
//           rst  in  1  asynchronous, active-high reset
//           bus  slave modport of rcas_acc_16bit_if (command, operand and
//                result streams plus acc / c_out / ovf / zero)
//
// Param   : LEN_W - width of the operand count; sequences run up to
//                   2^LEN_W - 1 operands. Must match the interface instance.
//------------------------------------------------------------------------------
module rcas_acc_16bit
    import rcas_acc_16bit_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
)
(
    input  logic            clk,
    input  logic            rst,
    rcas_acc_16bit_if.slave bus
);

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_acc;
    logic             r_c_out;
    logic             r_ovf;
    logic [LEN_W-1:0] r_count;

    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_op_ovf;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_xfer;
    logic             w_last;

    // ---------------------------------------------------------------------
    // Arithmetic: the only path that changes acc during a sequence
    // ---------------------------------------------------------------------
    rcas_16bit u_adder (
        .i_a    (r_acc),
        .i_b    (bus.in_data),
        .i_sel  (bus.in_sub),
        .o_sum  (w_sum),
        .o_cout (w_carry)
    );

    assign w_op_ovf = op_overflow(r_acc[WIDTH-1], bus.in_data[WIDTH-1],
                                  w_sum[WIDTH-1], bus.in_sub);

    // An operand moves on every edge where both sides agree.
    assign w_xfer = bus.in_valid && w_in_ready;

    // The operand being accepted is the final one of the sequence.
    assign w_last = (r_count == LEN_W'(1));

    // ---------------------------------------------------------------------
    // Controller: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // Controller: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: the default assignment at the top of the block gives the output a
    // value on every path through the case, so no latch is inferred; it also
    // sends the unused encoding back to ST_IDLE.
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    // An empty sequence has nothing to accept and goes
                    // straight to presenting the cleared result.
                    w_next_state = (bus.len == '0) ? ST_DONE : ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_next_state = (w_xfer && w_last) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                // start is not looked at here, so a start raised alongside
                // the result handshake is dropped.
                w_next_state = bus.out_ready ? ST_IDLE : ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Controller: outputs (Moore, from the state register only)
    // ---------------------------------------------------------------------
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_RUN:  w_in_ready  = 1'b1;
            ST_DONE: w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    // Outside of a start in IDLE and a transfer in RUN everything holds, so
    // the result stays readable after the consumer has taken it and until
    // the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_c_out <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_count <= bus.len;
                    end
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        r_acc   <= w_sum;
                        r_c_out <= w_carry;
                        r_ovf   <= r_ovf | w_op_ovf;
                        r_count <= r_count - LEN_W'(1);
                    end
                end
                default: begin
                    r_acc   <= r_acc;
                    r_c_out <= r_c_out;
                    r_ovf   <= r_ovf;
                    r_count <= r_count;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Interface outputs
    // ---------------------------------------------------------------------
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.acc       = r_acc;
    assign bus.c_out     = r_c_out;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = (r_acc == '0);

endmodule : rcas_acc_16bit

// File: tb/tb_rcas_acc_16bit.sv
//------------------------------------------------------------------------------
// tb_rcas_acc_16bit
//
// Self-checking bench for rcas_acc_16bit. A behavioural model computes each
// operation with integer arithmetic (unsigned sum for carry, signed sum for
// overflow) and tracks which phase the sequence is in; a compare loop checks
// every DUT output against it on each falling edge. Directed sequences with
// hand-computed results pin the model, followed by randomized sequences with
// random stalls on both handshakes.
//------------------------------------------------------------------------------
module tb_rcas_acc_16bit;

    localparam int LEN_W = 4;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rcas_acc_16bit_if #(.LEN_W(LEN_W)) bus ();

    rcas_acc_16bit #(.LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Operand list for the next sequence.
    logic [15:0] op_data [16];
    logic        op_sub  [16];

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    int          m_phase;
    logic [15:0] m_acc;
    logic        m_c;
    logic        m_ovf;
    int          m_left;

    // Returns {overflow, carry, result} for acc (+/-) b using plain integers.
    function automatic logic [17:0] ref_op(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input logic        sub);
        int   sa;
        int   sb;
        int   sr;
        int   ur;
        logic carry;
        logic ov;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            sr    = sa - sb;
            ur    = int'({16'd0, a}) - int'({16'd0, b});
            carry = (a >= b);
        end else begin
            sr    = sa + sb;
            ur    = int'({16'd0, a}) + int'({16'd0, b});
            carry = (ur > 65535);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, carry, ur[15:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= P_IDLE;
            m_acc   <= 16'd0;
            m_c     <= 1'b0;
            m_ovf   <= 1'b0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                P_IDLE: if (bus.start) begin
                    m_acc   <= 16'd0;
                    m_c     <= 1'b0;
                    m_ovf   <= 1'b0;
                    m_left  <= int'(bus.len);
                    m_phase <= (bus.len == '0) ? P_DONE : P_RUN;
                end
                P_RUN: if (bus.in_valid) begin
                    m_acc  <= ref_op(m_acc, bus.in_data, bus.in_sub)[15:0];
                    m_c    <= ref_op(m_acc, bus.in_data, bus.in_sub)[16];
                    m_ovf  <= m_ovf | ref_op(m_acc, bus.in_data, bus.in_sub)[17];
                    m_left <= m_left - 1;
                    if (m_left == 1) m_phase <= P_DONE;
                end
                default: if (bus.out_ready) m_phase <= P_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Checking helpers
    // ---------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_result(input string name, input logic [15:0] e_acc,
                                 input logic e_c, input logic e_ovf,
                                 input logic e_zero);
        check({name, "_acc"},  32'(bus.acc),   32'(e_acc));
        check({name, "_cout"}, 32'(bus.c_out), 32'(e_c));
        check({name, "_ovf"},  32'(bus.ovf),   32'(e_ovf));
        check({name, "_zero"}, 32'(bus.zero),  32'(e_zero));
    endtask

    function automatic logic [15:0] rnd_word();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            4:       return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    // Runs one full sequence from a falling edge in IDLE and returns at a
    // falling edge in IDLE after the result handshake.
    task automatic run_seq(input int n, input int idle_pct, input int hold);
        int k;
        int guard;
        k = 0;
        guard = 0;
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = LEN_W'($urandom);
        if (n == 0) check("len0_done_next", 32'(bus.out_valid), 32'd1);
        while (k < n && guard < 400) begin
            bus.in_valid = ($urandom_range(99) >= idle_pct);
            bus.in_data  = bus.in_valid ? op_data[k] : 16'($urandom);
            bus.in_sub   = bus.in_valid ? op_sub[k]  : 1'($urandom);
            if (bus.in_valid && bus.in_ready) k++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        check("operands_taken", 32'(k), 32'(n));
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", 32'(bus.out_valid), 32'd1);
        // Stalled consumer; stray operands must be ignored while done.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'($urandom);
            bus.in_data  = 16'($urandom);
            bus.in_sub   = 1'($urandom);
            @(negedge clk);
            check("out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        // Handshake with a simultaneous start, which must be dropped.
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = LEN_W'(5);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check("idle_after_handshake", 32'(bus.out_valid), 32'd0);
        check("start_ignored", 32'(bus.in_ready), 32'd0);
    endtask

    // ---------------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Main sequence with per-cycle compare loop
    // ---------------------------------------------------------------------
    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    check("cyc_in_ready",  32'(bus.in_ready),  32'(m_phase == P_RUN));
                    check("cyc_out_valid", 32'(bus.out_valid), 32'(m_phase == P_DONE));
                    check("cyc_acc",       32'(bus.acc),       32'(m_acc));
                    check("cyc_c_out",     32'(bus.c_out),     32'(m_c));
                    check("cyc_ovf",       32'(bus.ovf),       32'(m_ovf));
                    check("cyc_zero",      32'(bus.zero),      32'(m_acc == 16'd0));
                end
            end
        join_none

        // Outputs while held in reset.
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_zero",      32'(bus.zero),      32'd1);
        check("rst_acc",       32'(bus.acc),       32'd0);
        @(negedge clk);
        @(negedge clk);

        // Release reset and issue start in the same instant.
        rst = 1'b0;

        // Basic add: 10 + 20 + 5 = 35.
        op_data[0] = 16'd10; op_sub[0] = 1'b0;
        op_data[1] = 16'd20; op_sub[1] = 1'b0;
        op_data[2] = 16'd5;  op_sub[2] = 1'b0;
        run_seq(3, 0, 0);
        expect_result("basic_add", 16'd35, 1'b0, 1'b0, 1'b0);

        // 5 - 7 borrows.
        op_data[0] = 16'd5; op_sub[0] = 1'b0;
        op_data[1] = 16'd7; op_sub[1] = 1'b1;
        run_seq(2, 0, 1);
        expect_result("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // 7 - 5 does not borrow.
        op_data[0] = 16'd7; op_sub[0] = 1'b0;
        op_data[1] = 16'd5; op_sub[1] = 1'b1;
        run_seq(2, 0, 0);
        expect_result("sub_noborrow", 16'd2, 1'b1, 1'b0, 1'b0);

        // 7FFF + 1 overflows.
        op_data[0] = 16'h7FFF; op_sub[0] = 1'b0;
        op_data[1] = 16'h0001; op_sub[1] = 1'b0;
        run_seq(2, 0, 0);
        expect_result("ovf_set", 16'h8000, 1'b0, 1'b1, 1'b0);

        // 7FFF + 1 - 1: back to 7FFF, overflow stays set.
        op_data[0] = 16'h7FFF; op_sub[0] = 1'b0;
        op_data[1] = 16'h0001; op_sub[1] = 1'b0;
        op_data[2] = 16'h0001; op_sub[2] = 1'b1;
        run_seq(3, 0, 0);
        expect_result("ovf_sticky", 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Stalls on both sides.
        for (int i = 0; i < 4; i++) begin
            op_data[i] = rnd_word();
            op_sub[i]  = 1'($urandom);
        end
        run_seq(4, 50, 5);

        // Empty sequence.
        run_seq(0, 0, 2);
        expect_result("len0", 16'd0, 1'b0, 1'b0, 1'b1);

        // Longest sequence: 15 x 1111 = FFFF, crossing 7FFF on the way.
        for (int i = 0; i < 15; i++) begin
            op_data[i] = 16'h1111;
            op_sub[i]  = 1'b0;
        end
        run_seq(15, 0, 0);
        expect_result("max_len", 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a four-operand sequence.
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd3;
        bus.in_sub   = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("pre_rst_acc", 32'(bus.acc), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_acc",       32'(bus.acc),       32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_zero",      32'(bus.zero),      32'd1);
        check("mid_rst_ovf",       32'(bus.ovf),       32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(bus.in_ready), 32'd0);

        // Randomized sequences.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(15);
            for (int i = 0; i < 16; i++) begin
                op_data[i] = rnd_word();
                op_sub[i]  = 1'($urandom);
            end
            run_seq(n, $urandom_range(60), $urandom_range(4));
            // Idle gap with stray inputs that must not disturb anything.
            repeat ($urandom_range(3)) begin
                bus.in_valid  = 1'($urandom);
                bus.in_data   = 16'($urandom);
                bus.out_ready = 1'($urandom);
                @(negedge clk);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rcas_acc_16bit

// File: doc/rcas_acc_16bit.md
RCAS_ACC_16BIT -- requirements
Module: rcas_acc_16bit

Interface
REQ-001 Parameter: LEN_W, 4, width of the operand-count input; WIDTH is fixed at 16 by the adder.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of operands to accumulate; sampled with start.
REQ-006 in_valid  input  1  operand present on in_data/in_sub.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 in_data  input  16  operand.
REQ-009 in_sub  input  1  0: acc+in_data, 1: acc-in_data.
REQ-010 out_valid  output  1  final result held on acc/c_out/ovf/zero.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 acc  output  16  accumulator value.
REQ-013 c_out  output  1  carry of the most recent operation; for a subtract, 1 = no borrow.
REQ-014 ovf  output  1  sticky two's-complement overflow over the whole sequence.
REQ-015 zero  output  1  acc == 0.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 IDLE: in IDLE, start=1 SHALL clear acc, c_out and ovf, and load the remaining count with len.
REQ-018 Next state from IDLE: RUN if len != 0, or DONE if len == 0.
REQ-019 RUN: in RUN, in_ready SHALL be 1, and in IDLE and DONE it SHALL be 0.
REQ-020 Transfer: a transfer SHALL occur exactly on a clk edge with in_valid && in_ready.
REQ-021 On each transfer, acc SHALL load the adder result for (acc, in_data, sel=in_sub) in the same edge, giving 1-cycle latency.
REQ-022 On each transfer, c_out SHALL load the adder carry, and the remaining count SHALL decrement.
REQ-023 ovf SHALL be set, and remain set, when an operation overflows.
REQ-024 Add overflow condition: acc[15]==in_data[15] and result[15]!=acc[15].
REQ-025 Subtract overflow condition: acc[15]!=in_data[15] and result[15]!=acc[15].
REQ-026 Wrap-around: the result SHALL wrap modulo 2^16, with no saturation.
REQ-027 When the transfer with count==1 occurs, the state SHALL go to DONE on that edge.
REQ-028 With in_valid=0, RUN SHALL hold all state indefinitely.
REQ-029 DONE: out_valid SHALL be 1, and acc/c_out/ovf/zero SHALL be stable.
REQ-030 In DONE, out_valid && out_ready SHALL return the FSM to IDLE on that edge.
REQ-031 After leaving DONE, acc SHALL retain its value until the next start.
REQ-032 start outside IDLE SHALL be ignored, including start asserted in the same cycle as the DONE->IDLE handshake.
REQ-033 zero SHALL be combinational from acc and valid in all states.
REQ-034 The maximum sequence length SHALL be 2^LEN_W-1 operands.

Reset
REQ-035 Asserting rst SHALL immediately force state=IDLE, acc=0, c_out=0, ovf=0 and count=0.
REQ-036 Under reset, outputs SHALL be out_valid=0, in_ready=0 and zero=1.
REQ-037 Reset in RUN or DONE SHALL abort the sequence, and the partial result SHALL be discarded.
REQ-038 Release of rst SHALL need no clock edges before start is accepted.

Structure
REQ-039 The shared package SHALL hold WIDTH=16, the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default LEN_W.
REQ-040 The block SHALL instantiate exactly one rcas_16bit as its arithmetic sub-module, with inputs a=acc, b=in_data and sel=in_sub.
REQ-041 The adder SHALL be the only arithmetic path, with no behavioural + or - on acc.
REQ-042 The illegal state 2'd3 SHALL recover to IDLE.

Verification
REQ-043 Basic add: start, len=3; operands +10, +20, +5 (all add) -> out_valid after the 3rd transfer, acc=35, c_out=0, ovf=0, zero=0.
REQ-044 Subtract/borrow: len=2; +5, then -7 -> acc=16'hFFFE and c_out=0 (borrow).
REQ-045 Subtract/no borrow: len=2; +7, then -5 -> acc=2, c_out=1.
REQ-046 Sticky overflow: len=2; +16'h7FFF, then +1 -> acc=16'h8000, ovf=1.
REQ-047 Overflow stays set: a follow-up len=3 run of +7FFF, +1, -1 -> acc=16'h7FFF, ovf still 1.
REQ-048 Handshake stalls: in_valid toggled randomly and out_ready held low for 5 cycles -> acc unchanged while stalled, out_valid held, exactly one IDLE return on out_ready.
REQ-049 len=0 and mid-RUN reset: len=0 -> DONE next cycle with acc=0, zero=1; rst pulsed mid-RUN after 1 of 4 operands -> IDLE, acc=0, in_ready=0 without waiting for a clock edge.
